// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults and the stage record (valid + payload) for elastic_pipeline.
package pipe_pkg;
    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 5;
    typedef struct packed {
        logic                     valid;
        logic [DEFAULT_WIDTH-1:0] data;
    } stage_t;
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid/data register; ports clk, reset, load (take d), drop (clear valid), d, q.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter type rec_t = stage_t
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic drop,
    input  rec_t d,
    output rec_t q
);
    rec_t q_q, q_d;
    always_comb begin
        q_d = load ? d : rec_t'{valid: q_q.valid & ~drop, data: q_q.data};
    end
    always_ff @(posedge clk) begin
        if (reset) q_q <= '0;
        else q_q <= q_d;
    end
    assign q = q_q;
endmodule

// File: rtl/elastic_pipeline.sv
// elastic_pipeline: DEPTH-stage valid/ready pipeline with per-stage flush and registered occupancy.
// Ports: clk, reset, in_valid/in_ready/in_data, out_valid/out_ready/out_data, flush_mask, occupancy.
module elastic_pipeline
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic [DEPTH-1:0] flush_mask,
    output logic [CNTW-1:0]  occupancy
);
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } rec_t;
    logic [DEPTH-1:0] valid, nv;
    logic [WIDTH-1:0] data [DEPTH];
    logic [CNTW-1:0]  occ_q, occ_d;
    for (genvar g = 0; g < DEPTH; g++) begin : g_st
        logic adv, free, load;
        logic [WIDTH-1:0] src;
        rec_t q;
        // Ready chain runs combinationally from the output back to stage 0.
        if (g == DEPTH - 1) begin : g_last
            assign adv = valid[g] & ~flush_mask[g] & out_ready;
        end else begin : g_mid
            assign adv = valid[g] & ~flush_mask[g] & g_st[g+1].free;
        end
        if (g == 0) begin : g_first
            assign load = in_valid & in_ready;
            assign src  = in_data;
        end else begin : g_next
            assign load = g_st[g-1].adv;
            assign src  = data[g-1];
        end
        assign free = ~valid[g] | flush_mask[g] | adv;
        // Next-cycle valid, used only for the occupancy count.
        assign nv[g] = load | (valid[g] & ~flush_mask[g] & ~adv);
        pipe_stage #(.rec_t(rec_t)) u_stage (
            .clk  (clk),
            .reset(reset),
            .load (load),
            .drop (flush_mask[g] | adv),
            .d    (rec_t'{valid: 1'b1, data: src}),
            .q    (q)
        );
        assign valid[g] = q.valid;
        assign data[g]  = q.data;
    end
    assign in_ready  = g_st[0].free & ~reset;
    assign out_valid = valid[DEPTH-1] & ~flush_mask[DEPTH-1];
    assign out_data  = data[DEPTH-1];
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) occ_d = occ_d + CNTW'(nv[i]);
    end
    always_ff @(posedge clk) begin
        if (reset) occ_q <= '0;
        else occ_q <= occ_d;
    end
    assign occupancy = occ_q;
endmodule

// File: tb/tb_elastic_pipeline.sv
// tb_elastic_pipeline: directed and random checks of elastic_pipeline at DEPTH 5, 1 and 7.
module tb_elastic_pipeline;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic              reset;
    logic [2:0]        iv, ordy, ir, ov;
    logic [2:0][31:0]  idat, od;
    logic [2:0][6:0]   fm;
    logic [2:0]        occ5, occ7;
    logic [0:0]        occ1;
    int vectors = 0;
    int miscompares = 0;
    int dep[3] = '{5, 1, 7};
    bit mv[3][8];
    logic [31:0] md[3][8];
    typedef struct { int k; logic [31:0] v; } ent_t;
    ent_t sq[$];
    logic [31:0] sn = 32'h1000_0000;

    elastic_pipeline #(.WIDTH(32), .DEPTH(5)) u5 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .flush_mask(fm[0][4:0]), .occupancy(occ5));
    elastic_pipeline #(.WIDTH(32), .DEPTH(1)) u1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .flush_mask(fm[1][0:0]), .occupancy(occ1));
    elastic_pipeline #(.WIDTH(32), .DEPTH(7)) u7 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(idat[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .flush_mask(fm[2]), .occupancy(occ7));

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic int qcount(int k);
        int n = 0;
        foreach (sq[i]) if (sq[i].k == k) n++;
        return n;
    endfunction

    task automatic qpop(int k, output logic [31:0] v, output bit ok);
        ok = 1'b0;
        v = '0;
        for (int i = 0; i < sq.size(); i++) begin
            if (sq[i].k == k) begin
                v = sq[i].v;
                sq.delete(i);
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic qdel(int k, logic [31:0] v);
        for (int i = 0; i < sq.size(); i++) begin
            if (sq[i].k == k && sq[i].v === v) begin
                sq.delete(i);
                return;
            end
        end
    endtask

    task automatic qclear(int k);
        for (int i = sq.size() - 1; i >= 0; i--) if (sq[i].k == k) sq.delete(i);
    endtask

    // One clock: predict and check combinational outputs, update the model, then check occupancy.
    task automatic tick();
        bit adv[8];
        bit ire, ove, ld, ok;
        int d, cnt;
        logic [31:0] v, oo;
        #1;
        for (int k = 0; k < 3; k++) begin
            d = dep[k];
            ove = mv[k][d-1] && !fm[k][d-1];
            adv[d-1] = ove && ordy[k];
            for (int i = d - 2; i >= 0; i--)
                adv[i] = mv[k][i] && !fm[k][i] && (!mv[k][i+1] || fm[k][i+1] || adv[i+1]);
            ire = (!mv[k][0] || fm[k][0] || adv[0]) && !reset;
            chk("in_ready", 32'(ir[k]), 32'(ire));
            chk("out_valid", 32'(ov[k]), 32'(ove));
            if (reset) qclear(k);
            else begin
                if (ove && ordy[k]) begin
                    qpop(k, v, ok);
                    chk("scoreboard_nonempty", 32'(ok), 32'd1);
                    if (ok) chk("out_data", od[k], v);
                end
                if (iv[k] && ire) sq.push_back('{k, idat[k]});
            end
            for (int i = d - 1; i >= 0; i--) begin
                if (i == 0) ld = iv[k] && ire;
                else ld = adv[i-1];
                if (mv[k][i] && fm[k][i] && !reset) qdel(k, md[k][i]);
                if (reset) mv[k][i] = 1'b0;
                else if (ld) begin
                    mv[k][i] = 1'b1;
                    md[k][i] = (i == 0) ? idat[k] : md[k][i-1];
                end else if (fm[k][i] || adv[i]) mv[k][i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            cnt = 0;
            for (int i = 0; i < dep[k]; i++) cnt += int'(mv[k][i]);
            oo = (k == 0) ? 32'(occ5) : (k == 1) ? 32'(occ1) : 32'(occ7);
            chk("occupancy", oo, 32'(cnt));
        end
    endtask

    task automatic drive(bit v, logic [31:0] dat, bit r, logic [4:0] f);
        iv[0] = v;
        idat[0] = dat;
        ordy[0] = r;
        fm[0] = {2'b00, f};
    endtask

    task automatic idle0(int n, bit r);
        drive(1'b0, 32'h0, r, 5'b0);
        repeat (n) tick();
    endtask

    initial begin
        reset = 1'b1;
        iv = '0;
        ordy = '1;
        idat = '0;
        fm = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(ir[0]), 32'd0);
        reset = 1'b0;
        #1;
        chk("reset_out_valid", 32'(ov[0]), 32'd0);
        chk("reset_occupancy", 32'(occ5), 32'd0);
        // Streaming, no backpressure.
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 32'(i), 1'b1, 5'b0);
            if (i == 5) begin
                #1;
                chk("latency_early", 32'(ov[0]), 32'd0);
            end
            if (i == 6) begin
                #1;
                chk("latency_out_valid", 32'(ov[0]), 32'd1);
                chk("latency_out_data", od[0], 32'h1);
            end
            tick();
        end
        idle0(6, 1'b1);
        // Backpressure: fill then release.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hA0 + 32'(i), 1'b0, 5'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 5'b0);
        #1;
        chk("full_occupancy", 32'(occ5), 32'd5);
        chk("full_in_ready", 32'(ir[0]), 32'd0);
        tick();
        idle0(7, 1'b1);
        // Selective flush of stage 2.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hB0 + 32'(i), 1'b0, 5'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 5'b00100);
        tick();
        chk("flush_occupancy", 32'(occ5), 32'd4);
        idle0(8, 1'b1);
        chk("flush_drained", 32'(qcount(0)), 32'd0);
        // Full flush while accepting a new entry.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hC0 + 32'(i), 1'b0, 5'b0);
            tick();
        end
        drive(1'b1, 32'hCC, 1'b0, 5'b11111);
        tick();
        chk("fullflush_occupancy", 32'(occ5), 32'd1);
        idle0(8, 1'b1);
        chk("fullflush_drained", 32'(qcount(0)), 32'd0);
        // Reset with entries in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hD0 + 32'(i), 1'b0, 5'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 5'b0);
        reset = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(ir[0]), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_occupancy", 32'(occ5), 32'd0);
        chk("midrst_out_valid", 32'(ov[0]), 32'd0);
        chk("midrst_in_ready_after", 32'(ir[0]), 32'd1);
        idle0(6, 1'b1);
        // Random traffic on DEPTH=1 and DEPTH=7.
        for (int n = 0; n < 800; n++) begin
            for (int k = 1; k < 3; k++) begin
                iv[k] = ($urandom_range(0, 3) != 0);
                idat[k] = sn;
                sn++;
                ordy[k] = ($urandom_range(0, 9) < 6);
                fm[k] = ($urandom_range(0, 5) == 0) ? 7'($urandom) : 7'd0;
            end
            tick();
        end
        iv = '0;
        ordy = '1;
        fm = '0;
        repeat (12) tick();
        for (int k = 0; k < 3; k++) chk("final_drained", 32'(qcount(k)), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/elastic_pipeline.md
ELASTIC_PIPELINE -- requirements
Module: elastic_pipeline

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (>=1).
REQ-002 Parameter DEPTH, default 5, number of pipeline stages (>=1).
REQ-003 Parameter CNTW, default $clog2(DEPTH+1), occupancy counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_ready  output  1  stage 0 can accept this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  last stage holds a live entry.
REQ-010 out_ready  input  1  downstream accepts this cycle.
REQ-011 out_data  output  WIDTH  payload of last stage.
REQ-012 flush_mask  input  DEPTH  bit i kills the entry in stage i this cycle.
REQ-013 occupancy  output  CNTW  registered count of valid stages.

Function
REQ-014 Each stage i SHALL hold valid_i and data_i registers; stage 0 fed by in_*, stage i fed by stage i-1.
REQ-015 Stage i is free when ~valid_i | flush_mask[i] | adv_i, where adv_i is "stage i content moves on this cycle"; adv_(DEPTH-1) = out_valid & out_ready.
REQ-016 Stage i (i<DEPTH-1) SHALL advance when valid_i & ~flush_mask[i] & free_(i+1); ready chain is combinational, so a full pipe with out_ready=1 accepts one entry per cycle.
REQ-017 in_ready SHALL equal free_0 & ~reset.
REQ-018 Transfer into stage 0 occurs iff in_valid & in_ready; no transfer SHALL be lost or duplicated.
REQ-019 out_valid SHALL equal valid_(DEPTH-1) & ~flush_mask[DEPTH-1]; out_data = data_(DEPTH-1) (don't-care when out_valid=0).
REQ-020 Latency: with no backpressure and no flush, an entry accepted at edge N appears on out_valid in the cycle after edge N+DEPTH-1 (DEPTH cycles of residence).
REQ-021 Flushed stage: content discarded, never output; stage may load from stage i-1 in the same cycle unless stage i-1 is also flushed or empty.
REQ-022 flush_mask all ones SHALL empty the pipe in one cycle while still accepting a new input into stage 0.
REQ-023 When a stage neither advances nor is flushed, it SHALL hold data and valid unchanged (stall); data registers of empty stages need not be updated.
REQ-024 Order SHALL be preserved: outputs leave in acceptance order, minus flushed entries.
REQ-025 occupancy SHALL equal the number of set valid_i after each edge; it never exceeds DEPTH and never wraps.
REQ-026 DEPTH=1 SHALL degenerate to a single elastic register with the same rules.

Reset
REQ-027 While reset=1 at an edge: all valid_i<=0, all data_i<=0, occupancy<=0; inputs ignored.
REQ-028 During a reset cycle in_ready=0; out_valid SHALL be 0 in the cycle after reset.
REQ-029 Reset asserted mid-operation SHALL drop all in-flight entries with no output.

Structure
REQ-030 A shared package pipe_pkg SHALL hold default WIDTH/DEPTH constants and the stage record type (valid + payload).
REQ-031 One sub-module pipe_stage (valid/data register with load, hold, kill controls) SHALL be instantiated DEPTH times via generate; ready chain and occupancy logic live in elastic_pipeline.

Verification
REQ-032 Streaming: WIDTH=32, DEPTH=5, out_ready=1, push 0x1..0x10 back-to-back -> out_data 0x1..0x10 consecutively, first valid 5 cycles after first accept, in_ready never 0.
REQ-033 Backpressure: fill with 0xA0..0xA4, out_ready=0 -> occupancy=5, in_ready=0 next cycle; release -> 0xA0..0xA4 in order, no loss.
REQ-034 Selective flush: pipe holds 0xB0..0xB4 (0xB4 in stage 0), flush_mask=5'b00100 one cycle -> 0xB2 never output, others in order, occupancy drops by 1.
REQ-035 Full flush plus input: flush_mask=5'b11111 with in_valid=1, in_data=0xCC -> next cycle occupancy=1, only 0xCC eventually output.
REQ-036 Reset mid-stream: assert reset with 3 entries in flight -> occupancy=0, out_valid=0 after edge, in_ready=0 during reset, 1 after.
REQ-037 Random valid/ready/flush (DEPTH=1 and DEPTH=7), scoreboard model -> order preserved, no loss/duplication, occupancy always matches model.
